// File: rtl/dual_grant_pkg.sv
// Shared constants and helpers for the dual-slot grant scheduler.
// Slot FSM encodings are plain localparams so legacy code can use them directly.
package dual_grant_pkg;

    localparam int N_REQ = 12;
    localparam int IDX_W = 4;
    localparam logic [IDX_W-1:0] IDX_NONE = 4'hF;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_GRANTED = 1'b1;

    // IDX_NONE is outside 0..N_REQ-1, so it decodes to an all-zero vector.
    function automatic logic [N_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] oh;
        oh = '0;
        for (int i = 0; i < N_REQ; i++) begin
            oh[i] = (idx == IDX_W'(i));
        end
        return oh;
    endfunction

endpackage

// File: rtl/dual_grant_sched_prio_enc2.sv
// Dual priority encoder: highest and next-highest set index of a request vector.
// Pure combinational; unused outputs read IDX_NONE.
module prio_enc2
    import dual_grant_pkg::*;
(
    input  logic [N_REQ-1:0] vec_i,
    output logic [IDX_W-1:0] first_o,
    output logic [IDX_W-1:0] second_o,
    output logic             first_valid_o,
    output logic             second_valid_o
);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        first_o        = IDX_NONE;
        second_o       = IDX_NONE;
        first_valid_o  = 1'b0;
        second_valid_o = 1'b0;
        // Scanning upward, each newly found bit demotes the previous winner to second.
        for (int i = 0; i < N_REQ; i++) begin
            if (vec_i[i]) begin
                second_o       = first_o;
                second_valid_o = first_valid_o;
                first_o        = IDX_W'(i);
                first_valid_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dual_grant_sched.sv
// Two-slot round-robin grant scheduler with per-slot hold timeout.
// All outputs come straight from registers.
module dual_grant_sched
    import dual_grant_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       done,
    output logic [1:0]       gnt_valid,
    output logic [IDX_W-1:0] gnt_idx0,
    output logic [IDX_W-1:0] gnt_idx1,
    output logic [N_REQ-1:0] gnt_onehot,
    output logic [1:0]       tout
);

    localparam logic [3:0] CNT_LAST = 4'(HOLD_MAX - 1);

    logic [1:0]                  state_q, state_d;
    logic [1:0][IDX_W-1:0]       idx_q, idx_d;
    logic [1:0][3:0]             cnt_q, cnt_d;
    logic [N_REQ-1:0]            served_q, served_d;
    logic [N_REQ-1:0]            onehot_q, onehot_d;
    logic [1:0]                  tout_q, tout_d;

    logic [N_REQ-1:0] elig_raw, avail, elig;
    logic             new_round;
    logic [IDX_W-1:0] first_idx, second_idx;
    logic             first_valid, second_valid;
    logic [1:0]             grant_en;
    logic [1:0][IDX_W-1:0]  grant_idx;

    // An index already held by either slot is never eligible, even if it is releasing now.
    assign avail     = req & ~onehot_q;
    assign elig_raw  = avail & ~served_q;
    assign new_round = (elig_raw == '0) && (avail != '0);
    assign elig      = new_round ? avail : elig_raw;

    prio_enc2 u_prio_enc2 (
        .vec_i          (elig),
        .first_o        (first_idx),
        .second_o       (second_idx),
        .first_valid_o  (first_valid),
        .second_valid_o (second_valid)
    );

    always_comb begin
        grant_en  = '0;
        grant_idx = {IDX_NONE, IDX_NONE};
        if (state_q == {ST_IDLE, ST_IDLE}) begin
            grant_en  = {second_valid, first_valid};
            grant_idx = {second_idx, first_idx};
        end else if (state_q[0] == ST_IDLE) begin
            grant_en[0]  = first_valid;
            grant_idx[0] = first_idx;
        end else if (state_q[1] == ST_IDLE) begin
            grant_en[1]  = first_valid;
            grant_idx[1] = first_idx;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        tout_d   = '0;
        served_d = new_round ? '0 : served_q;
        for (int s = 0; s < 2; s++) begin
            if (state_q[s] == ST_GRANTED) begin
                // done / req-drop win over timeout; a released slot waits one idle cycle.
                if (done[s] || ((req & idx_onehot(idx_q[s])) == '0)) begin
                    state_d[s] = ST_IDLE;
                    idx_d[s]   = IDX_NONE;
                    cnt_d[s]   = '0;
                end else if (cnt_q[s] == CNT_LAST) begin
                    state_d[s] = ST_IDLE;
                    idx_d[s]   = IDX_NONE;
                    cnt_d[s]   = '0;
                    tout_d[s]  = 1'b1;
                end else begin
                    cnt_d[s] = cnt_q[s] + 4'd1;
                end
            end else if (grant_en[s]) begin
                state_d[s] = ST_GRANTED;
                idx_d[s]   = grant_idx[s];
                cnt_d[s]   = '0;
                served_d   = served_d | idx_onehot(grant_idx[s]);
            end
        end
        onehot_d = idx_onehot(idx_d[0]) | idx_onehot(idx_d[1]);
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= {ST_IDLE, ST_IDLE};
            idx_q    <= {IDX_NONE, IDX_NONE};
            cnt_q    <= '0;
            served_q <= '0;
            onehot_q <= '0;
            tout_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            served_q <= served_d;
            onehot_q <= onehot_d;
            tout_q   <= tout_d;
        end
    end

    assign gnt_valid  = state_q;
    assign gnt_idx0   = idx_q[0];
    assign gnt_idx1   = idx_q[1];
    assign gnt_onehot = onehot_q;
    assign tout       = tout_q;

endmodule

// File: doc/dual_grant_sched.md
DUAL_GRANT_SCHED -- requirements
Module: dual_grant_sched

Interface
REQ-001 SHALL have parameter HOLD_MAX, default 8, meaning maximum consecutive cycles one slot may hold a grant (legal 2..15).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port req, input, 12, with one request line per requester, bit i = requester i.
REQ-005 SHALL have port done, input, 2, with done[s] = slot s owner finished.
REQ-006 SHALL have port gnt_valid, output, 2, meaning slot s currently holds a grant.
REQ-007 SHALL have ports gnt_idx0 and gnt_idx1, output, 4 each, giving the requester index held by slot 0 and slot 1.
REQ-008 SHALL have port gnt_onehot, output, 12, equal to the OR of the one-hot decode of both held indices.
REQ-009 SHALL have port tout, output, 2, a one-cycle pulse marking a slot released by timeout.

Function
REQ-010 SHALL register all outputs; no combinational path from req/done to any output.
REQ-011 SHALL form eligible vector E = req & ~served & ~held, where held = gnt_onehot and served = internal 12-bit round mask.
REQ-012 SHALL, when E == 0 and (req & ~held) != 0, start a new round in the same cycle: served cleared, E recomputed as req & ~held.
REQ-013 SHALL select first = highest set index of E and second = next-highest set index of E (the same dual priority encoding used by the datapath).
REQ-014 SHALL, at an edge where both slots are idle, grant first to slot 0 and second to slot 1; if E has one bit, grant only slot 0.
REQ-015 SHALL, at an edge where exactly one slot is idle, grant first to that slot.
REQ-016 SHALL set the served bit of every index granted at that edge.
REQ-017 SHALL have grant latency of one edge: req sampled high at edge n -> gnt_valid visible after edge n.
REQ-018 SHALL drive gnt_idx of an idle slot as 4'hF (IDX_NONE).
REQ-019 SHALL release slot s at the edge where done[s]=1 or req[gnt_idx_s]=0; the slot SHALL NOT be regranted at that same edge (one idle cycle minimum).
REQ-020 SHALL ignore done[s] while slot s is idle.
REQ-021 SHALL keep a per-slot hold counter, zeroed at grant and incremented each edge while granted; gnt_valid SHALL be high for exactly HOLD_MAX cycles if never released earlier.
REQ-022 SHALL, at an edge where the counter equals HOLD_MAX-1 and no done/req-drop occurs, release the slot and assert tout[s] for the following cycle only.
REQ-023 SHALL give done/req-drop precedence over timeout on the same edge (no tout).
REQ-024 SHALL handle each slot's release independently; simultaneous release of both slots is legal.

Reset
REQ-025 SHALL, on rst high, immediately force gnt_valid=00, gnt_idx0=gnt_idx1=4'hF, gnt_onehot=0, tout=00, served=0, counters=0, regardless of clk.
REQ-026 SHALL make the first grant possible at the first rising clk edge after rst deasserts.

Structure
REQ-027 SHALL take N_REQ=12, IDX_W=4, IDX_NONE=4'hF from shared package dual_grant_pkg.
REQ-028 SHALL instantiate one combinational sub-module prio_enc2 (12-bit vector -> first, second, valid flags) for selection.
REQ-029 SHALL implement per-slot control as a two-state machine IDLE/GRANTED.

Verification
REQ-030 SHALL cover reset: rst pulse mid-grant -> gnt_valid=00, idx=F/F, gnt_onehot=000 without a clock edge.
REQ-031 SHALL cover dual grant: req=0x208 from idle -> after one edge gnt_idx0=9, gnt_idx1=3, gnt_onehot=0x208.
REQ-032 SHALL cover fairness: req=0xFFF held, done=11 pulsed one cycle after each grant -> pairs (11,10),(9,8),(7,6),(5,4),(3,2),(1,0), then (11,10) again.
REQ-033 SHALL cover timeout: req=0x001, done=0, HOLD_MAX=8 -> slot0 idx=0 for 8 cycles, tout=01 one cycle, one idle cycle, then regrant idx=0.
REQ-034 SHALL cover release: req bit dropped while granted -> slot idle next edge, tout=00; done and timeout on the same edge -> tout=00.
REQ-035 SHALL cover a single idle slot: slot1 holding 5, req=0x030 -> slot0 gets 4 after one edge.
